// File: rtl/pdm_tx_pkg.sv
// pdm_tx_pkg: shared types and constants for the PDM playback transmitter.
package pdm_tx_pkg;

    localparam int PCM_W = 8;
    localparam logic [PCM_W-1:0] PCM_MIDSCALE = 8'h80;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/pdm_tx_fifo.sv
// pdm_tx_fifo: small synchronous sample FIFO with occupancy count.
// A push is refused when full, even if a pop happens in the same cycle.
module pdm_tx_fifo
    import pdm_tx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [PCM_W-1:0]         wdata,
    output logic [PCM_W-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [PCM_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_FULL);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Sample storage; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/pdm_tx.sv
// pdm_tx: PCM-to-PDM playback transmitter with first-order delta-sigma
// modulator, bit-clock divider and sample FIFO.
// Build option PDM_TX_UNDERRUN_HOLD_EN: when defined, an underrun repeats
// the last sample; otherwise the modulator falls back to mid-scale silence.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | amplifier off, divider parked at 0, outputs low
// WAIT  | amplifier on, divider running, waiting for a first sample
// RUN   | modulating cur_sample, one PDM bit per bit period
module pdm_tx
    import pdm_tx_pkg::*;
#(
    parameter int CLK_DIV    = 50,
    parameter int OSR        = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [PCM_W-1:0]              pcm_data,
    input  logic                          pcm_valid,
    output logic                          pcm_ready,
    output logic                          mclk,
    output logic                          ampPWM,
    output logic                          ampSD,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int SW = $clog2(OSR);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [SW-1:0] SMP_LAST = SW'(OSR - 1);

    state_t           state;
    logic [DW-1:0]    div_cnt;
    logic [DW-1:0]    div_next;
    logic [SW-1:0]    sample_cnt;
    logic [PCM_W-1:0] acc;
    logic [PCM_W:0]   acc_next;
    logic [PCM_W-1:0] cur_sample;
    logic             bit_tick;
    logic             boundary;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [PCM_W-1:0] fifo_rdata;

    assign bit_tick  = (state != IDLE) && (div_cnt == DIV_LAST);
    assign boundary  = (state == RUN) && bit_tick && (sample_cnt == SMP_LAST);
    assign div_next  = bit_tick ? '0 : div_cnt + DW'(1);
    assign acc_next  = {1'b0, acc} + {1'b0, cur_sample};
    assign fifo_pop  = enable && bit_tick && !fifo_empty && ((state == WAIT) || boundary);
    assign pcm_ready = !fifo_full;

    pdm_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (pcm_valid),
        .pop   (fifo_pop),
        .wdata (pcm_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Sequencer, divider and modulator; mclk is computed from the next
    // divider value so its rising edge lines up with each new ampPWM bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            div_cnt    <= '0;
            sample_cnt <= '0;
            acc        <= '0;
            cur_sample <= PCM_MIDSCALE;
            mclk       <= 1'b0;
            ampPWM     <= 1'b0;
            ampSD      <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (state == IDLE) begin
                div_cnt <= '0;
                mclk    <= 1'b0;
                ampPWM  <= 1'b0;
                if (enable) begin
                    state <= WAIT;
                    ampSD <= 1'b1;
                    mclk  <= 1'b1;
                end
            end else if (!enable) begin
                state      <= IDLE;
                div_cnt    <= '0;
                sample_cnt <= '0;
                acc        <= '0;
                mclk       <= 1'b0;
                ampPWM     <= 1'b0;
                ampSD      <= 1'b0;
            end else begin
                div_cnt <= div_next;
                mclk    <= (div_next < DIV_HALF);
                case (state)
                    WAIT: begin
                        if (bit_tick && !fifo_empty) begin
                            cur_sample <= fifo_rdata;
                            sample_cnt <= '0;
                            state      <= RUN;
                        end
                    end
                    RUN: begin
                        if (bit_tick) begin
                            acc    <= acc_next[PCM_W-1:0];
                            ampPWM <= acc_next[PCM_W];
                            if (sample_cnt == SMP_LAST) begin
                                sample_cnt <= '0;
                                if (!fifo_empty) begin
                                    cur_sample <= fifo_rdata;
                                end else begin
                                    underrun <= 1'b1;
`ifdef PDM_TX_UNDERRUN_HOLD_EN
                                    cur_sample <= cur_sample;
`else
                                    cur_sample <= PCM_MIDSCALE;
`endif
                                end
                            end else begin
                                sample_cnt <= sample_cnt + SW'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pdm_tx.sv
// tb_pdm_tx: randomized bench for pdm_tx with a cycle-level reference model.
// The model tracks the sample queue and derives each PDM bit from the
// cumulative sum of played samples: bit n = floor(S_n/256) - floor(S_(n-1)/256).
module tb_pdm_tx;

    localparam int CLK_DIV    = 4;
    localparam int OSR        = 256;
    localparam int FIFO_DEPTH = 4;
    localparam int SPER       = CLK_DIV * OSR;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] pcm_data;
    logic       pcm_valid;
    logic       pcm_ready;
    logic       mclk;
    logic       ampPWM;
    logic       ampSD;
    logic       underrun;
    logic [2:0] fifo_level;

    pdm_tx #(
        .CLK_DIV    (CLK_DIV),
        .OSR        (OSR),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .pcm_data   (pcm_data),
        .pcm_valid  (pcm_valid),
        .pcm_ready  (pcm_ready),
        .mclk       (mclk),
        .ampPWM     (ampPWM),
        .ampSD      (ampSD),
        .underrun   (underrun),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input int obs, input int expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, expv, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {P_OFF, P_WAIT, P_RUN} mphase_t;
    mphase_t ph = P_OFF;
    int  q[$];
    int  cur = 128;
    int  acc_sum = 0;
    int  cyc = 0;
    int  bit_idx = 0;
    int  ones = 0;
    int  push_val = 0;
    bit  exp_pwm = 1'b0;
    bit  exp_ur = 1'b0;
    bit  en_pend = 1'b0;
    bit  push_pend = 1'b0;

    // Model step for the preceding rising edge, then compare all outputs.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            ph        = P_OFF;
            en_pend   = 1'b0;
            push_pend = 1'b0;
            exp_pwm   = 1'b0;
            acc_sum   = 0;
            cyc       = 0;
        end else begin
            exp_ur = 1'b0;
            if (!en_pend) begin
                ph      = P_OFF;
                exp_pwm = 1'b0;
            end else if (ph == P_OFF) begin
                ph  = P_WAIT;
                cyc = 0;
            end else begin
                cyc++;
                if (cyc % CLK_DIV == 0) begin
                    if (ph == P_WAIT) begin
                        if (q.size() > 0) begin
                            cur     = q.pop_front();
                            ph      = P_RUN;
                            acc_sum = 0;
                            bit_idx = 0;
                            ones    = 0;
                        end
                    end else begin
                        exp_pwm = ((acc_sum + cur) / 256) != (acc_sum / 256);
                        acc_sum += cur;
                        ones    += int'(ampPWM);
                        bit_idx++;
                        if (bit_idx == OSR) begin
                            check_eq("density", ones, cur);
                            bit_idx = 0;
                            ones    = 0;
                            if (q.size() > 0) begin
                                cur = q.pop_front();
                            end else begin
                                exp_ur = 1'b1;
`ifndef PDM_TX_UNDERRUN_HOLD_EN
                                cur = 128;
`endif
                            end
                        end
                    end
                end
            end
            if (push_pend) q.push_back(push_val);
            check_eq("mclk", int'(mclk),
                     int'((ph != P_OFF) && ((cyc % CLK_DIV) < CLK_DIV / 2)));
            check_eq("ampSD", int'(ampSD), int'(ph != P_OFF));
            check_eq("ampPWM", int'(ampPWM), int'(exp_pwm));
            check_eq("underrun", int'(underrun), int'(exp_ur));
            check_eq("fifo_level", int'(fifo_level), q.size());
            check_eq("pcm_ready", int'(pcm_ready), int'(q.size() < FIFO_DEPTH));
            push_pend = pcm_valid && (q.size() < FIFO_DEPTH);
            push_val  = int'(pcm_data);
            en_pend   = enable;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_sample(input logic [7:0] v);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        pcm_data  = v;
        pcm_valid = 1'b1;
        while (!done && n < 2000) begin
            @(negedge clk);
            done = pcm_ready;
            @(posedge clk);
            #1;
            n++;
        end
        pcm_valid = 1'b0;
        if (!done) check_eq("push_timeout", 0, 1);
    endtask

    task automatic wait_level(input int lvl, input int limit);
        int n;
        n = 0;
        while (int'(fifo_level) != lvl && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("wait_level", int'(fifo_level), lvl);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ampPWM"}, int'(ampPWM), 0);
        check_eq({tag, "_ampSD"}, int'(ampSD), 0);
        check_eq({tag, "_mclk"}, int'(mclk), 0);
        check_eq({tag, "_underrun"}, int'(underrun), 0);
        check_eq({tag, "_level"}, int'(fifo_level), 0);
        check_eq({tag, "_ready"}, int'(pcm_ready), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] s [5];
        reset     = 1'b1;
        enable    = 1'b0;
        pcm_valid = 1'b0;
        pcm_data  = 8'h00;
        tick(3);
        check_reset_outputs("reset");
        reset = 1'b0;
        tick(2);

        // Fill while disabled; the fifth sample waits for the first pop.
        s[0] = 8'hC0;
        s[1] = 8'($urandom_range(0, 255));
        s[2] = 8'($urandom_range(0, 255));
        s[3] = 8'($urandom_range(0, 255));
        s[4] = 8'h40;
        for (int i = 0; i < 4; i++) push_sample(s[i]);
        pcm_data  = s[4];
        pcm_valid = 1'b1;
        tick(5);
        @(negedge clk);
        check_eq("full_level", int'(fifo_level), 4);
        check_eq("full_ready", int'(pcm_ready), 0);
        check_eq("idle_ampSD", int'(ampSD), 0);
        @(posedge clk);
        #1;
        enable = 1'b1;
        push_sample(s[4]);
        tick(6 * SPER + 20);

        // Drop enable mid-sample with two queued, then resume.
        push_sample(8'($urandom_range(0, 255)));
        push_sample(8'h80);
        push_sample(8'($urandom_range(0, 255)));
        wait_level(2, SPER + 100);
        tick(100);
        enable = 1'b0;
        tick(1);
        @(negedge clk);
        check_eq("drop_ampSD", int'(ampSD), 0);
        check_eq("drop_level", int'(fifo_level), 2);
        check_eq("drop_ampPWM", int'(ampPWM), 0);
        tick(20);
        enable = 1'b1;
        tick(3 * SPER + 20);

        // Asynchronous reset mid-run with three samples queued.
        for (int i = 0; i < 4; i++) push_sample(8'($urandom_range(0, 255)));
        wait_level(3, SPER + 100);
        tick(50);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("midrun_reset");
        tick(3);
        reset = 1'b0;
        tick(2);

        // Random traffic with gaps and one enable bounce.
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push_sample(8'($urandom_range(0, 255)));
            tick($urandom_range(0, 700));
            if (i == 4) begin
                enable = 1'b0;
                tick($urandom_range(1, 30));
                enable = 1'b1;
            end
        end
        tick(2 * SPER + 50);
        enable = 1'b0;
        tick(5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
